// File: rtl/branch_resolution_unit_pkg.sv
// Shared definitions for the execute-stage branch resolution unit:
// branch condition codes and the post-redirect FSM state type.
package branch_resolution_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    BRU_RUN    = 1'b0,
    BRU_SHADOW = 1'b1
  } bru_state_t;

endpackage

// File: rtl/branch_resolution_unit_comparator.sv
// Combinational branch condition evaluator. Unused funct3 codes
// (010, 011) evaluate as not-taken.
module branch_comparator
  import branch_resolution_unit_pkg::*;
(
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [2:0]  i_funct3,
  output logic        o_cond
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1 == i_rs2);
  assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu = (i_rs1 < i_rs2);

  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_cond = w_eq;
      F3_BNE:  o_cond = !w_eq;
      F3_BLT:  o_cond = w_lt;
      F3_BGE:  o_cond = !w_lt;
      F3_BLTU: o_cond = w_ltu;
      F3_BGEU: o_cond = !w_ltu;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Execute-stage branch/jump resolution with mispredict flush and post-redirect
// shadow FSM. Define BRU_PERF_COUNTERS_EN to build the saturating perf counters.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int SHADOW_CYCLES = 1,
  parameter int CNT_W         = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Stall_E,
  input  logic             Branch_E,
  input  logic             Jump_E,
  input  logic             Jalr_E,
  input  logic [2:0]       Funct3_E,
  input  logic [31:0]      RS1_E,
  input  logic [31:0]      RS2_E,
  input  logic [31:0]      Imm_E,
  input  logic [31:0]      PC_E,
  input  logic             Predict_Taken_E,
  output logic             Branch_Taken_E,
  output logic [31:0]      PC_Target_E,
  output logic [31:0]      PC_Plus_4_E,
  output logic             Resolve_Valid_E,
  output logic             Mispredict_E,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [CNT_W-1:0] Branch_Count,
  output logic [CNT_W-1:0] Mispredict_Count
);

  localparam logic [1:0] SHADOW_LOAD = 2'(SHADOW_CYCLES - 1);

  bru_state_t  r_state;
  bru_state_t  w_state_nxt;
  logic [1:0]  r_shadow_cnt;
  logic [1:0]  w_shadow_cnt_nxt;
  logic        w_cond;
  logic        w_active;
  logic [31:0] w_jalr_sum;

  branch_comparator u_cmp (
    .i_rs1    (RS1_E),
    .i_rs2    (RS2_E),
    .i_funct3 (Funct3_E),
    .o_cond   (w_cond)
  );

  assign w_jalr_sum  = RS1_E + Imm_E;
  assign PC_Target_E = (Jump_E && Jalr_E) ? {w_jalr_sum[31:1], 1'b0} : (PC_E + Imm_E);
  assign PC_Plus_4_E = PC_E + 32'd4;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= BRU_RUN;
      r_shadow_cnt <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_shadow_cnt <= w_shadow_cnt_nxt;
    end
  end

  // Shadow countdown only advances on unstalled cycles.
  always_comb begin
    w_state_nxt      = r_state;
    w_shadow_cnt_nxt = r_shadow_cnt;
    case (r_state)
      BRU_RUN: begin
        if (Mispredict_E) begin
          w_state_nxt      = BRU_SHADOW;
          w_shadow_cnt_nxt = SHADOW_LOAD;
        end
      end
      BRU_SHADOW: begin
        if (!Stall_E) begin
          if (r_shadow_cnt == 2'd0) w_state_nxt = BRU_RUN;
          else                      w_shadow_cnt_nxt = r_shadow_cnt - 2'd1;
        end
      end
      default: w_state_nxt = BRU_RUN;
    endcase
  end

  always_comb begin
    w_active        = !RST && !Stall_E && (r_state == BRU_RUN);
    Branch_Taken_E  = w_active && ((Branch_E && w_cond) || Jump_E);
    Resolve_Valid_E = w_active && Branch_E;
    Mispredict_E    = w_active && (Branch_E || Jump_E) && (Predict_Taken_E != Branch_Taken_E);
    Flush_D         = Mispredict_E;
    Flush_E         = Mispredict_E;
  end

`ifdef BRU_PERF_COUNTERS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (!Stall_E) begin
      if (Resolve_Valid_E && (r_branch_cnt != CNT_MAX))
        r_branch_cnt <= r_branch_cnt + CNT_ONE;
      if (Mispredict_E && (r_mispredict_cnt != CNT_MAX))
        r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
    end
  end

  assign Branch_Count     = r_branch_cnt;
  assign Mispredict_Count = r_mispredict_cnt;
`else
  assign Branch_Count     = '0;
  assign Mispredict_Count = '0;
`endif

endmodule
